// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite definitions for the data-memory arbiters.
// Contents: response codes and the arbiter state encoding.
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick, purely combinational.
// Ports:
//   req[1:0]  - request per requester
//   last_id   - index of the requester served most recently
//   gnt_valid - at least one request is present
//   gnt_id    - chosen requester; on a tie the one that was not served last
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_id;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_lite_arb2.sv
// Two-master to one-slave AXI4-lite arbiter. A whole transaction (AR+R or
// AW+W+B) is granted to one master at a time, round-robin between masters,
// with at most one transaction outstanding toward the slave. All forwarding
// is combinational from the registered grant and phase-done flags.
//
// Ports:
//   clk, rstn          - clock, synchronous active-low reset
//   m_aw*/m_w*/m_b*    - two master write channels, master i at [i*W +: W]
//   m_ar*/m_r*         - two master read channels
//   s_aw*..s_r*        - single AXI4-lite master port toward the memory
//   grant_valid        - a transaction is in progress
//   grant_id           - index of the granted master
//
// state | meaning
// IDLE  | no grant; pick a master from the current requests
// WR    | write granted: AW and W forwarded independently, then B
// RD    | read granted: AR forwarded, then R
module axi_lite_arb2 #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [1:0]              m_awvalid,
  input  logic [2*AWIDTH-1:0]     m_awaddr,
  input  logic [5:0]              m_awprot,
  output logic [1:0]              m_awready,
  input  logic [1:0]              m_wvalid,
  input  logic [2*DWIDTH-1:0]     m_wdata,
  input  logic [2*(DWIDTH/8)-1:0] m_wstrb,
  output logic [1:0]              m_wready,
  output logic [1:0]              m_bvalid,
  output logic [3:0]              m_bresp,
  input  logic [1:0]              m_bready,
  input  logic [1:0]              m_arvalid,
  input  logic [2*AWIDTH-1:0]     m_araddr,
  input  logic [5:0]              m_arprot,
  output logic [1:0]              m_arready,
  output logic [1:0]              m_rvalid,
  output logic [2*DWIDTH-1:0]     m_rdata,
  output logic [3:0]              m_rresp,
  input  logic [1:0]              m_rready,
  output logic                    s_awvalid,
  output logic [AWIDTH-1:0]       s_awaddr,
  output logic [2:0]              s_awprot,
  input  logic                    s_awready,
  output logic                    s_wvalid,
  output logic [DWIDTH-1:0]       s_wdata,
  output logic [DWIDTH/8-1:0]     s_wstrb,
  input  logic                    s_wready,
  input  logic                    s_bvalid,
  input  logic [1:0]              s_bresp,
  output logic                    s_bready,
  output logic                    s_arvalid,
  output logic [AWIDTH-1:0]       s_araddr,
  output logic [2:0]              s_arprot,
  input  logic                    s_arready,
  input  logic                    s_rvalid,
  input  logic [DWIDTH-1:0]       s_rdata,
  input  logic [1:0]              s_rresp,
  output logic                    s_rready,
  output logic                    grant_valid,
  output logic                    grant_id
);
  import axi_lite_pkg::*;

  localparam int SW = DWIDTH / 8;

  arb_state_t state;
  logic       last_id;
  logic       aw_done, w_done, ar_done;
  logic [1:0] req;
  logic       pick_valid, pick_id;
  logic       wr_act, rd_act;

  // wvalid alone does not open a transaction; only an address phase does
  assign req = m_awvalid | m_arvalid;

  rr_pick2 u_pick (
    .req       (req),
    .last_id   (last_id),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  // Gating with rstn keeps every valid/ready low while reset is held,
  // not just from the first reset edge onward.
  assign wr_act = rstn && (state == WR);
  assign rd_act = rstn && (state == RD);

  // Responses are fanned out to both masters; only the granted one sees valid.
  assign m_bresp = {2{s_bresp}};
  assign m_rresp = {2{s_rresp}};
  assign m_rdata = {2{s_rdata}};

  always_comb begin
    s_awaddr  = m_awaddr[grant_id*AWIDTH +: AWIDTH];
    s_awprot  = m_awprot[grant_id*3 +: 3];
    s_wdata   = m_wdata[grant_id*DWIDTH +: DWIDTH];
    s_wstrb   = m_wstrb[grant_id*SW +: SW];
    s_araddr  = m_araddr[grant_id*AWIDTH +: AWIDTH];
    s_arprot  = m_arprot[grant_id*3 +: 3];
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bvalid  = 2'b00;
    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    if (wr_act) begin
      s_awvalid           = m_awvalid[grant_id] & ~aw_done;
      m_awready[grant_id] = s_awready & ~aw_done;
      s_wvalid            = m_wvalid[grant_id] & ~w_done;
      m_wready[grant_id]  = s_wready & ~w_done;
      // an early B from the slave is neither forwarded nor accepted
      s_bready            = m_bready[grant_id] & aw_done & w_done;
      m_bvalid[grant_id]  = s_bvalid & aw_done & w_done;
    end
    if (rd_act) begin
      s_arvalid           = m_arvalid[grant_id] & ~ar_done;
      m_arready[grant_id] = s_arready & ~ar_done;
      s_rready            = m_rready[grant_id] & ar_done;
      m_rvalid[grant_id]  = s_rvalid & ar_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= 1'b0;
      last_id     <= 1'b1;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      ar_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_valid <= 1'b1;
            grant_id    <= pick_id;
            state       <= m_awvalid[pick_id] ? WR : RD;
          end
        end
        WR: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready)   w_done  <= 1'b1;
          if (s_bvalid && s_bready) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            last_id     <= grant_id;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            ar_done     <= 1'b0;
          end
        end
        RD: begin
          if (s_arvalid && s_arready) ar_done <= 1'b1;
          if (s_rvalid && s_rready) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            last_id     <= grant_id;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            ar_done     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: the bench plays both masters and the
// memory slave; inputs change just after the falling edge, outputs are
// checked 1 ns later.
module tb_axi_lite_arb2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [5:0]  m_awprot, m_arprot;
  logic [7:0]  m_wstrb;
  logic [3:0]  m_bresp, m_rresp;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        grant_valid, grant_id;

  int checks = 0;
  int failures = 0;
  int lat;
  int bcount;

  always #5 clk = ~clk;

  axi_lite_arb2 #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // every valid/ready the arbiter drives, in one vector
  logic [14:0] hs_vec;
  assign hs_vec = {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
                   m_awready, m_wready, m_bvalid, m_arready, m_rvalid};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet_m1(input string tag);
    chk(tag, {m_awready[1], m_wready[1], m_arready[1], m_rvalid[1], m_bvalid[1]}, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m_awvalid = 0; m_wvalid = 0; m_arvalid = 0;
    m_bready = 2'b11; m_rready = 2'b11;
    m_awaddr = 0; m_araddr = 0; m_wdata = 0; m_wstrb = 0;
    m_awprot = 6'b010_001; m_arprot = 6'b110_001;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    repeat (2) @(negedge clk);
    #1 chk("rst_hold_hs", hs_vec, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_hs", hs_vec, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
  endtask

  // Slave side of one read; the master's arvalid is retired at the AR
  // handshake unless rearm asks it to keep requesting.
  task automatic serve_rd(input int id, input logic [31:0] addr, input logic [31:0] data,
                          input int ar_wait, input bit rearm, output int n);
    n = 0;
    while (!s_arvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!s_arvalid) begin
      chk("rd_timeout", 0, 1);
      return;
    end
    chk("rd_gid", grant_id, id);
    chk("rd_gv", grant_valid, 1);
    chk("rd_addr", s_araddr, addr);
    chk("rd_prot", s_arprot, (id == 1) ? 3'b110 : 3'b001);
    for (int i = 0; i < ar_wait; i++) begin
      chk("rd_arready_wait", m_arready, 0);
      @(negedge clk); #1;
    end
    s_arready = 1'b1;
    #1 chk("rd_m_arready", m_arready, (id == 1) ? 2'b10 : 2'b01);
    @(negedge clk);
    s_arready = 1'b0;
    if (!rearm) m_arvalid[id] = 1'b0;
    s_rvalid = 1'b1; s_rdata = data; s_rresp = 2'b00;
    #1;
    chk("rd_ar_done", s_arvalid, 0);
    chk("rd_rvalid", m_rvalid, (id == 1) ? 2'b10 : 2'b01);
    chk("rd_rdata", m_rdata[id*32 +: 32], data);
    chk("rd_rready", s_rready, 1);
    @(negedge clk);
    s_rvalid = 1'b0;
    #1 chk("rd_release", grant_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    do_reset();

    // single read from m0, slave arready two cycles late
    @(negedge clk);
    m_arvalid[0] = 1'b1; m_araddr[31:0] = 32'h010;
    #1 chk("t1_pre_grant", s_arvalid, 0);
    serve_rd(0, 32'h010, 32'hDEADBEEF, 2, 1'b0, lat);
    chk("t1_latency", lat, 1);
    chk_quiet_m1("t1_m1_quiet");

    // simultaneous reads from reset: 0,1,0,1,0
    do_reset();
    @(negedge clk);
    m_araddr = {32'h200, 32'h100};
    m_arvalid = 2'b11;
    #1;
    serve_rd(0, 32'h100, 32'h0000_0A00, 0, 1'b1, lat);
    serve_rd(1, 32'h200, 32'h0000_0B01, 0, 1'b1, lat);
    serve_rd(0, 32'h100, 32'h0000_0A02, 0, 1'b1, lat);
    serve_rd(1, 32'h200, 32'h0000_0B03, 0, 1'b0, lat);
    serve_rd(0, 32'h100, 32'h0000_0A04, 0, 1'b0, lat);

    // m1 write: W accepted three cycles ahead of AW, early B ignored
    bcount = 0;
    @(negedge clk);
    m_awvalid[1] = 1'b1; m_awaddr[63:32] = 32'h020;
    m_wvalid[1] = 1'b1; m_wdata[63:32] = 32'h12345678; m_wstrb[7:4] = 4'hF;
    #1 chk("t3_pre_grant", s_awvalid, 0);
    @(negedge clk);
    s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b00;
    #1;
    chk("t3_gid", grant_id, 1);
    chk("t3_awaddr", s_awaddr, 32'h020);
    chk("t3_awprot", s_awprot, 3'b010);
    chk("t3_wdata", s_wdata, 32'h12345678);
    chk("t3_wstrb", s_wstrb, 4'hF);
    chk("t3_m_wready", m_wready, 2'b10);
    chk("t3_early_b_bready", s_bready, 0);
    chk("t3_early_b_bvalid", m_bvalid, 0);
    chk("t3_awready_low", m_awready, 0);
    @(negedge clk);
    s_wready = 1'b0; m_wvalid[1] = 1'b0;
    #1;
    chk("t3_w_done", s_wvalid, 0);
    chk("t3_aw_pending", s_awvalid, 1);
    chk("t3_early_b_still", {s_bready, m_bvalid}, 0);
    s_bvalid = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("t3_wait_bready", s_bready, 0);
      if (m_bvalid[1]) bcount++;
    end
    s_awready = 1'b1;
    #1 chk("t3_m_awready", m_awready, 2'b10);
    @(negedge clk);
    s_awready = 1'b0; m_awvalid[1] = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b10;
    #1;
    chk("t3_aw_done", s_awvalid, 0);
    chk("t3_bready", s_bready, 1);
    chk("t3_bvalid", m_bvalid, 2'b10);
    chk("t3_bresp", m_bresp[3:2], 2'b10);
    if (m_bvalid[1]) bcount++;
    @(negedge clk);
    s_bvalid = 1'b0;
    #1;
    chk("t3_release", grant_valid, 0);
    if (m_bvalid[1]) bcount++;
    chk("t3_bvalid_once", bcount, 1);

    // m0 write and read together: write first, read right after one idle cycle
    @(negedge clk);
    m_awvalid[0] = 1'b1; m_awaddr[31:0] = 32'h050;
    m_wvalid[0] = 1'b1; m_wdata[31:0] = 32'hCAFEF00D; m_wstrb[3:0] = 4'h3;
    m_arvalid[0] = 1'b1; m_araddr[31:0] = 32'h060;
    #1;
    @(negedge clk); #1;
    chk("t5_awvalid", s_awvalid, 1);
    chk("t5_gid", grant_id, 0);
    chk("t5_no_ar", s_arvalid, 0);
    chk("t5_awaddr", s_awaddr, 32'h050);
    chk("t5_wstrb", s_wstrb, 4'h3);
    s_awready = 1'b1; s_wready = 1'b1;
    #1;
    chk("t5_ready", {m_awready, m_wready, m_arready}, 6'b01_01_00);
    @(negedge clk);
    s_awready = 1'b0; s_wready = 1'b0;
    m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b11;
    #1;
    chk("t5_bvalid", m_bvalid, 2'b01);
    chk("t5_bresp", m_bresp[1:0], 2'b11);
    @(negedge clk);
    s_bvalid = 1'b0;
    #1 chk("t5_release", grant_valid, 0);
    serve_rd(0, 32'h060, 32'h5A5A_A5A5, 0, 1'b0, lat);
    chk("t5_rd_latency", lat, 1);

    // reset with AR already accepted and R pending
    @(negedge clk);
    m_arvalid[0] = 1'b1; m_araddr[31:0] = 32'h030;
    @(negedge clk);
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; m_arvalid[0] = 1'b0;
    #1 chk("t6_ar_done", {grant_valid, s_arvalid}, 2'b10);
    rstn = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BAD_0BAD;
    @(negedge clk); #1;
    chk("t6_rst_hs", hs_vec, 0);
    chk("t6_rst_gv", grant_valid, 0);
    rstn = 1'b1; s_rvalid = 1'b0;
    @(negedge clk); #1;
    chk("t6_idle_after", {grant_valid, hs_vec}, 0);
    m_arvalid[1] = 1'b1; m_araddr[63:32] = 32'h040;
    #1;
    serve_rd(1, 32'h040, 32'h7777_1111, 1, 1'b0, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
